// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver front end: synchroniser, oversampling FSM and a one-entry valid/ready output register.
// Optional even-parity bit after D7 is enabled by defining UART_RX_PARITY_EN.
module uart_rx_frontend #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   input  logic       ready_i,
   output logic       frame_err_o,
   output logic       parity_err_o,
   output logic       overrun_o,
   output logic       busy_o
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_BREAK
   } state_t;

   logic          r_sync1;
   logic          r_sync2;
   logic          r_rx_prev;
   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift;
   logic [7:0]    r_data;
   logic          r_valid;
   logic          r_frame_err;
   logic          r_overrun;
`ifdef UART_RX_PARITY_EN
   logic          r_par_bit;
   logic          r_parity_err;
`endif

   logic w_rx_s;
   logic w_fall;
   logic w_tick;
   logic w_handshake;
   logic w_par_bad;

   assign w_rx_s      = r_sync2;
   assign w_fall      = r_rx_prev & ~w_rx_s;
   assign w_tick      = (r_cnt == '0);
   assign w_handshake = r_valid & ready_i;
`ifdef UART_RX_PARITY_EN
   // Even parity: data bits and parity bit together must hold an even number of ones.
   assign w_par_bad   = (^r_shift) ^ r_par_bit;
`else
   assign w_par_bad   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_sync1   <= rx_i;
         r_sync2   <= r_sync1;
         r_rx_prev <= r_sync2;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bit    <= 1'b0;
         r_parity_err <= 1'b0;
`endif
      end else begin
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_parity_err <= 1'b0;
`endif
         // A completion later in this block overrides this clear.
         if (w_handshake) begin
            r_valid <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (w_fall) begin
                  r_cnt   <= HALF_LOAD;
                  r_state <= S_START;
               end
            end

            S_START: begin
               if (w_tick) begin
                  if (!w_rx_s) begin
                     r_cnt     <= FULL_LOAD;
                     r_bit_idx <= '0;
                     r_state   <= S_DATA;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end

            S_DATA: begin
               if (w_tick) begin
                  r_shift <= {w_rx_s, r_shift[7:1]};
                  r_cnt   <= FULL_LOAD;
                  if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     r_state <= S_PARITY;
`else
                     r_state <= S_STOP;
`endif
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end

`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (w_tick) begin
                  r_par_bit <= w_rx_s;
                  r_cnt     <= FULL_LOAD;
                  r_state   <= S_STOP;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
`endif

            S_STOP: begin
               if (w_tick) begin
                  if (!w_rx_s) begin
                     r_frame_err <= 1'b1;
                     r_state     <= S_BREAK;
                  end else if (w_par_bad) begin
`ifdef UART_RX_PARITY_EN
                     r_parity_err <= 1'b1;
`endif
                     r_state <= S_IDLE;
                  end else begin
                     // Leaving at mid-stop lets a back-to-back start bit be caught.
                     r_state <= S_IDLE;
                     if (!r_valid || ready_i) begin
                        r_data  <= r_shift;
                        r_valid <= 1'b1;
                     end else begin
                        r_overrun <= 1'b1;
                     end
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end

            S_BREAK: begin
               if (w_rx_s) begin
                  r_state <= S_IDLE;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign data_o      = r_data;
   assign valid_o     = r_valid;
   assign frame_err_o = r_frame_err;
   assign overrun_o   = r_overrun;
   assign busy_o      = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
   assign parity_err_o = r_parity_err;
`else
   assign parity_err_o = 1'b0;
`endif

endmodule
